decoder_frame_rx: RTL and testbench
===================================

// Module: decoder_frame_rx
// PURPOSE
//  Serial front end for the decoder. Receives UART-style frames on one pin:
//  start, 7 data bits LSB first, optional even parity, stop.
//  Buffers good codewords in a small FIFO and presents them to the decoder's
//  7-bit io_in with a valid/ready handshake. Flags framing, parity and overflow errors.
// PARAMETERS
//  DATA_W        7   codeword width; matches decoder io_in
//  CLKS_PER_BIT  16  clocks per serial bit; must be even and >= 4
//  PARITY_EN     1   1: a parity bit follows the data; 0: no parity bit
//  FIFO_DEPTH    2   codeword buffer entries; power of two, >= 2
// PORTS
//  clock      in   1       single clock; all logic on posedge
//  reset_n    in   1       synchronous, active-low reset
//  rx         in   1       async serial input; idles high
//  out_data   out  DATA_W  codeword at FIFO head; drives decoder io_in
//  out_valid  out  1       out_data holds a codeword
//  out_ready  in   1       decoder accepts the head entry when valid && ready
//  rx_busy    out  1       high in every state except IDLE
//  frame_err  out  1       one-cycle pulse: stop bit sampled low
//  par_err    out  1       one-cycle pulse: parity mismatch
//  overflow   out  1       sticky: a good frame was dropped because the FIFO was full
//  clr_ovf    in   1       clears overflow; a new overflow in the same cycle wins
// BEHAVIOUR
//  Reset (reset_n==0 at posedge):
//   - state=IDLE; FIFO emptied; bit counter and clock divider = 0.
//   - rx sync flops = 1; all outputs 0 (out_data = 0).
//   - Reset asserted mid-frame aborts the frame; no error pulses are produced.
//  Input: rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
//  FSM:
//   - IDLE -> START when rx_s is 0; the divider is cleared.
//   - START: wait CLKS_PER_BIT/2 clocks, then resample.
//     rx_s==1 is a glitch: go to IDLE with no error. rx_s==0: go to DATA, divider=0.
//   - DATA: sample rx_s each time the divider reaches CLKS_PER_BIT-1, i.e. at bit
//     centres. Shift in LSB first. After DATA_W samples go to PARITY
//     (PARITY_EN=1) or STOP (PARITY_EN=0).
//   - PARITY: one sample; store bad = ^{data,bit} != 0 (even parity). -> STOP.
//   - STOP: one sample.
//       rx_s==0: frame_err pulse, frame dropped.
//       rx_s==1 and bad: par_err pulse, frame dropped.
//       otherwise: push to FIFO.
//     -> IDLE in all three cases. Framing takes priority over parity, so both
//     pulses never fire together.
//  Timing:
//   - A pushed word shows on out_valid/out_data the clock after the stop sample.
//   - Frame start to out_valid is about 2 + (1.5 + DATA_W + PARITY_EN)*CLKS_PER_BIT clocks.
//  FIFO / handshake:
//   - Pop when out_valid && out_ready.
//   - Push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop
//     happens in the same cycle.
//   - Otherwise the word is dropped and overflow is set.
//   - out_data stays stable while out_valid && !out_ready.
//   - Push and pop together on an empty FIFO is impossible, since valid needs count>0.
//  Widths: divider is $clog2(CLKS_PER_BIT) bits; bit counter is $clog2(DATA_W+1)
//   bits; FIFO pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH+1) bits.
// STRUCTURE
//  decoder_pkg: rx_state_t enum {IDLE,START,DATA,PARITY,STOP}; DATA_W_C=7;
//   function even_par(). Shared with decoder_proj.
//  Sub-module decoder_rx_fifo (DEPTH, WIDTH): push/pop, full/empty, count, and
//   the same-cycle pop-then-push rule. The FSM, divider and synchroniser stay in
//   this module.
// TESTING (CLKS_PER_BIT=4, PARITY_EN=1, FIFO_DEPTH=2, out_ready=1 unless stated)
//  1. Send 7'b1110011 with parity bit 1 and stop bit 1
//     -> one out_valid pulse, out_data=7'b1110011, no error pulses.
//  2. Same data, parity bit 0 -> par_err pulses once; out_valid stays 0.
//  3. Stop bit 0 on a valid frame -> frame_err pulses once; FIFO unchanged.
//  4. 1-clock low glitch on rx while IDLE -> back to IDLE, rx_busy returns to 0,
//     no valid, no errors.
//  5. out_ready=0; send 0x01, 0x02, 0x03
//     -> FIFO holds 0x01,0x02; 0x03 is dropped and overflow=1.
//     Then out_ready=1 -> 0x01 then 0x02 in order; clr_ovf clears overflow.
//  6. reset_n low in the middle of the DATA bits -> IDLE, FIFO empty, no pulses.
//     The next clean frame is received correctly.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types and helpers for the decoder front end
package decoder_pkg;

    localparam int DATA_W_C = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Even parity over data and parity bit: 1 means the frame is bad.
    function automatic logic even_par(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/decoder_rx_fifo.sv
// rtl/decoder_rx_fifo.sv - small codeword FIFO with same-cycle pop-then-push when full
module decoder_rx_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 7
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign valid_o = (cnt_q != '0);
    assign rdata_o = mem_q[rd_q];
    assign full    = (cnt_q == FULL_C);
    assign do_pop  = pop_i && valid_o;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && !do_push;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_frame_rx.sv
// rtl/decoder_frame_rx.sv - UART-style serial receiver feeding decoder io_in via a FIFO
module decoder_frame_rx
    import decoder_pkg::*;
#(
    parameter int DATA_W       = DATA_W_C,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              rx_busy,
    output logic              frame_err,
    output logic              par_err,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    rx_state_t         state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              bad_q, bad_d;
    logic              ferr_q, ferr_d;
    logic              perr_q, perr_d;
    logic              ovf_q, ovf_d;
    logic              rx_meta_q, rx_s_q;
    logic              push;
    logic              drop;
    logic              div_end;

    assign div_end   = (div_q == DIV_LAST);
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = ferr_q;
    assign par_err   = perr_q;
    assign overflow  = ovf_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        data_d  = data_q;
        bad_d   = bad_q;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    div_d   = '0;
                    bad_d   = 1'b0;
                end
            end
            START: begin
                // Re-check half a bit later so a short low glitch is ignored.
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DATA: begin
                if (div_end) begin
                    div_d  = '0;
                    data_d = {rx_s_q, data_q[DATA_W-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            PARITY: begin
                if (div_end) begin
                    div_d   = '0;
                    bad_d   = even_par(32'({rx_s_q, data_q}));
                    state_d = STOP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            STOP: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = IDLE;
                    if (!rx_s_q) begin
                        ferr_d = 1'b1;
                    end else if (bad_q) begin
                        perr_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            bad_q     <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            bad_q     <= bad_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovf_q     <= ovf_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    decoder_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_W)
    ) u_fifo (
        .clk_i   (clock),
        .resetn_i(reset_n),
        .push_i  (push),
        .wdata_i (data_q),
        .pop_i   (out_ready),
        .rdata_o (out_data),
        .valid_o (out_valid),
        .drop_o  (drop)
    );

endmodule

// File: tb/tb_decoder_frame_rx.sv
// tb/tb_decoder_frame_rx.sv - directed table-driven bench for decoder_frame_rx
module tb_decoder_frame_rx;

    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rx;
    logic [6:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       par_err;
    logic       overflow;
    logic       clr_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] got_mem [0:63];
    int got_n  = 0;
    int ferr_n = 0;
    int perr_n = 0;

    typedef struct {
        logic [6:0] data;
        logic       par;
        logic       stop;
        int         exp_v;
        logic [6:0] exp_d;
        int         exp_f;
        int         exp_p;
    } vec_t;

    vec_t vecs [7];

    always #5 clock = ~clock;

    decoder_frame_rx #(
        .DATA_W(7),
        .CLKS_PER_BIT(CPB),
        .PARITY_EN(1),
        .FIFO_DEPTH(2)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rx       (rx),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .rx_busy  (rx_busy),
        .frame_err(frame_err),
        .par_err  (par_err),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always @(negedge clock) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                got_mem[got_n % 64] = out_data;
                got_n = got_n + 1;
            end
            if (frame_err) ferr_n = ferr_n + 1;
            if (par_err)   perr_n = perr_n + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    initial begin
        int v0, f0, p0, busy_seen;

        vecs[0] = '{7'b1110011, 1'b1, 1'b1, 1, 7'b1110011, 0, 0};
        vecs[1] = '{7'b1110011, 1'b0, 1'b1, 0, 7'h00,      0, 1};
        vecs[2] = '{7'b1110011, 1'b1, 1'b0, 0, 7'h00,      1, 0};
        vecs[3] = '{7'h00,      1'b0, 1'b1, 1, 7'h00,      0, 0};
        vecs[4] = '{7'h7F,      1'b1, 1'b1, 1, 7'h7F,      0, 0};
        vecs[5] = '{7'h55,      1'b0, 1'b1, 1, 7'h55,      0, 0};
        vecs[6] = '{7'h2A,      1'b0, 1'b0, 0, 7'h00,      1, 0};

        reset_n   = 1'b0;
        rx        = 1'b1;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_rx_busy", rx_busy, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_errs", {frame_err, par_err}, 0);

        for (int i = 0; i < 7; i++) begin
            v0 = got_n; f0 = ferr_n; p0 = perr_n;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            tick(4);
            chk($sformatf("vec%0d_valid_cnt", i), got_n - v0, vecs[i].exp_v);
            if (vecs[i].exp_v == 1)
                chk($sformatf("vec%0d_data", i), got_mem[v0 % 64], vecs[i].exp_d);
            chk($sformatf("vec%0d_frame_err", i), ferr_n - f0, vecs[i].exp_f);
            chk($sformatf("vec%0d_par_err", i), perr_n - p0, vecs[i].exp_p);
            chk($sformatf("vec%0d_busy_idle", i), rx_busy, 0);
        end

        // Glitch: one clock of low while idle.
        v0 = got_n; f0 = ferr_n; p0 = perr_n;
        busy_seen = 0;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (rx_busy) busy_seen = 1;
        end
        tick(4);
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_busy_back", rx_busy, 0);
        chk("glitch_no_valid", got_n - v0, 0);
        chk("glitch_no_err", (ferr_n - f0) + (perr_n - p0), 0);

        // Overflow: FIFO of two, three frames with the consumer stalled.
        out_ready = 1'b0;
        v0 = got_n;
        send_frame(7'h01, 1'b1, 1'b1);
        send_frame(7'h02, 1'b1, 1'b1);
        chk("ovf_not_yet", overflow, 0);
        send_frame(7'h03, 1'b0, 1'b1);
        tick(2);
        chk("ovf_set", overflow, 1);
        chk("ovf_head_valid", out_valid, 1);
        chk("ovf_head_data", out_data, 7'h01);
        chk("ovf_stalled_none", got_n - v0, 0);
        out_ready = 1'b1;
        tick(4);
        chk("ovf_drain_cnt", got_n - v0, 2);
        chk("ovf_drain_first", got_mem[v0 % 64], 7'h01);
        chk("ovf_drain_second", got_mem[(v0 + 1) % 64], 7'h02);
        chk("ovf_empty", out_valid, 0);
        chk("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        tick(1);
        chk("ovf_cleared", overflow, 0);

        // Reset in the middle of the data bits.
        v0 = got_n; f0 = ferr_n; p0 = perr_n;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset_n = 1'b0;
        rx      = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(CPB * 12);
        chk("midrst_busy", rx_busy, 0);
        chk("midrst_valid", got_n - v0, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_no_err", (ferr_n - f0) + (perr_n - p0), 0);
        send_frame(7'h5A, 1'b0, 1'b1);
        tick(4);
        chk("post_rst_cnt", got_n - v0, 1);
        chk("post_rst_data", got_mem[v0 % 64], 7'h5A);
        chk("post_rst_no_err", (ferr_n - f0) + (perr_n - p0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
